// File: rtl/seq_divider_32.sv
// Multi-cycle radix-2 restoring divider, signed or unsigned, one quotient bit per clock.
// The no-borrow decision comes from the carry-out of a 32-bit subtract (a + ~b + 1).
//
// state | meaning
// IDLE  | waiting for start
// PREP  | zero-divisor check, magnitudes and sign bookkeeping
// ITER  | 32 shift/subtract steps
// FIXUP | apply result signs
// DONE  | one-cycle done pulse; start accepted here too
module seq_divider_32 #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIXUP, S_DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] dvd_r, dvs_r, q_reg, rem;
  logic             sgn_r, neg_q, neg_r;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic [WIDTH-1:0] dvd_mag, dvs_mag, rem_sh, sum_dif;
  logic [WIDTH:0]   sub_full;
  logic             no_borrow;

  function automatic logic [WIDTH-1:0] neg2(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  always_comb begin
    accept    = start && (state == S_IDLE || state == S_DONE);
    dvd_mag   = (sgn_r && dvd_r[WIDTH-1]) ? neg2(dvd_r) : dvd_r;
    dvs_mag   = (sgn_r && dvs_r[WIDTH-1]) ? neg2(dvs_r) : dvs_r;
    rem_sh    = {rem[WIDTH-2:0], q_reg[WIDTH-1]};
    // carry-out of rem_sh + ~dvs_mag + 1 is set exactly when rem_sh >= dvs_mag
    sub_full  = {1'b0, rem_sh} + {1'b0, ~dvs_mag} + (WIDTH+1)'(1);
    sum_dif   = sub_full[WIDTH-1:0];
    no_borrow = sub_full[WIDTH];
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nx = S_PREP;
      S_PREP: begin
        busy     = 1'b1;
        state_nx = (dvs_r == '0) ? S_DONE : S_ITER;
      end
      S_ITER: begin
        busy = 1'b1;
        if (cnt == LAST) state_nx = S_FIXUP;
      end
      S_FIXUP: begin
        busy     = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = start ? S_PREP : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      dvd_r       <= '0;
      dvs_r       <= '0;
      sgn_r       <= 1'b0;
      q_reg       <= '0;
      rem         <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        dvd_r       <= dividend;
        dvs_r       <= divisor;
        sgn_r       <= is_signed;
        div_by_zero <= 1'b0;
      end
      case (state)
        S_PREP: begin
          if (dvs_r == '0) begin
            quotient    <= '1;
            remainder   <= dvd_r;
            div_by_zero <= 1'b1;
          end else begin
            q_reg <= dvd_mag;
            rem   <= '0;
            cnt   <= '0;
            neg_q <= sgn_r && (dvd_r[WIDTH-1] ^ dvs_r[WIDTH-1]);
            neg_r <= sgn_r && dvd_r[WIDTH-1];
          end
        end
        S_ITER: begin
          rem   <= no_borrow ? sum_dif : rem_sh;
          q_reg <= {q_reg[WIDTH-2:0], no_borrow};
          cnt   <= cnt + CW'(1);
        end
        S_FIXUP: begin
          quotient  <= neg_q ? neg2(q_reg) : q_reg;
          remainder <= neg_r ? neg2(rem) : rem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_32.sv
// Randomized scoreboard bench for seq_divider_32: driver pushes expected results,
// a negedge monitor pops and compares on each done pulse.
module tb_seq_divider_32;

  logic        clk = 1'b0;
  logic        rst, start, is_signed;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  seq_divider_32 dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] last_q = '0, last_r = '0;
  logic        last_z = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: plain integer division with truncation toward zero.
  function automatic void model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb_l;
    z = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else if (sgn) begin
      sa   = longint'($signed(a));
      sb_l = longint'($signed(b));
      q    = 32'(sa / sb_l);
      r    = 32'(sa % sb_l);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      last_q = '0;
      last_r = '0;
      last_z = 1'b0;
    end else if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.z});
        check("done_cycle", cyc, e.cyc);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        last_q = e.q;
        last_r = e.r;
        last_z = e.z;
      end
    end else if (!busy) begin
      check("held_quotient", quotient, last_q);
      check("held_remainder", remainder, last_r);
      check("held_dbz", {31'd0, div_by_zero}, {31'd0, last_z});
    end
  end

  // Issue one division; returns at posedge+1 of cycle 1 (PREP) with c1 = cyc there.
  task automatic issue(input bit sgn, input logic [31:0] a, input logic [31:0] b, output int c1);
    int   n = 0;
    exp_t e;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) check("wait_idle_timeout", 32'd1, 32'd0);
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c1 = cyc;
    model(sgn, a, b, e.q, e.r, e.z);
    e.cyc = c1 + ((b == 32'd0) ? 1 : 34);
    sb.push_back(e);
  endtask

  initial begin
    int c1;
    int busy_bad;
    int n;
    logic [31:0] a, b;
    bit sgn;

    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;

    // 100/7 with busy window check and an ignored start at cycle 10
    issue(1'b0, 32'd100, 32'd7, c1);
    busy_bad = 0;
    for (int k = 0; k < 34; k++) begin
      if (!busy) busy_bad++;
      if (k == 9) begin
        dividend = 32'hDEAD_BEEF; divisor = 32'd3; is_signed = 1'b1; start = 1'b1;
      end
      if (k == 10) start = 1'b0;
      if (k < 33) begin
        @(posedge clk); #1;
      end
    end
    check("busy_window", busy_bad, 0);

    // Back-to-back directed cases (each issued during the previous DONE cycle)
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, c1);
    issue(1'b1, 32'd7, 32'hFFFF_FFFE, c1);
    issue(1'b0, 32'h1234_5678, 32'd0, c1);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, c1);
    issue(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, c1);
    issue(1'b1, 32'h1234_5678, 32'd0, c1);

    // Reset in the middle of ITER: division abandoned, outputs cleared
    issue(1'b0, 32'hCAFE_F00D, 32'd13, c1);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(sb.pop_back());
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_quotient", quotient, 32'd0);
    check("midrst_remainder", remainder, 32'd0);
    check("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    issue(1'b0, 32'd100, 32'd7, c1);

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      issue(sgn, a, b, c1);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 40)) @(posedge clk);
        #1;
      end
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
